// File: rtl/alu8_sequencer_if.sv
// Bundles the request, ALU-drive and response signals of the 8-bit ALU sequencer.
// Valid/ready rule: a transfer happens at a rising clk edge where valid and ready are
// both high; the source holds valid and its payload steady until that edge.
interface alu8_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       req_cin;

  logic [3:0] alusel;
  logic [3:0] aluin_a;
  logic [3:0] aluin_b;
  logic       Cin;
  logic [3:0] alu_y;
  logic       alu_cf;
  logic       alu_ovf;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_y;
  logic       rsp_nf;
  logic       rsp_zf;
  logic       rsp_cf;
  logic       rsp_ovf;

  modport master (
    input  req_valid, req_op, req_a, req_b, req_cin,
    input  alu_y, alu_cf, alu_ovf,
    input  rsp_ready,
    output req_ready,
    output alusel, aluin_a, aluin_b, Cin,
    output rsp_valid, rsp_y, rsp_nf, rsp_zf, rsp_cf, rsp_ovf
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, req_cin,
    output alu_y, alu_cf, alu_ovf,
    output rsp_ready,
    input  req_ready,
    input  alusel, aluin_a, aluin_b, Cin,
    input  rsp_valid, rsp_y, rsp_nf, rsp_zf, rsp_cf, rsp_ovf
  );
endinterface

// File: rtl/alu8_sequencer.sv
// Runs 8-bit operations as two passes through an external combinational 4-bit ALU,
// low nibble first, chaining carry/borrow into the high pass through Cin.
module alu8_sequencer #(
  parameter logic [3:0] IDLE_SEL = 4'b0111
) (
  input  logic               clk,
  input  logic               rst,
  alu8_sequencer_if.master   bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e     state_q;
  logic [2:0] op_q;
  logic [3:0] a_hi_q;
  logic [3:0] b_hi_q;
  logic [3:0] res_lo_q;
  logic       carry_q;

  logic [3:0] alusel_q;
  logic [3:0] aluin_a_q;
  logic [3:0] aluin_b_q;
  logic       alu_cin_q;

  logic       rsp_valid_q;
  logic [7:0] rsp_y_q;
  logic       rsp_nf_q;
  logic       rsp_zf_q;
  logic       rsp_cf_q;
  logic       rsp_ovf_q;

  // op[2] marks the logic ops; op[1] selects subtract; op[0] pulls in the external carry.
  function automatic logic [3:0] low_sel(input logic [2:0] op);
    return {op[2], 1'b0, op[1:0]};
  endfunction

  function automatic logic [3:0] high_sel(input logic [2:0] op);
    return op[2] ? {2'b10, op[1:0]} : {2'b00, op[1], 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      a_hi_q      <= 4'd0;
      b_hi_q      <= 4'd0;
      res_lo_q    <= 4'd0;
      carry_q     <= 1'b0;
      alusel_q    <= IDLE_SEL;
      aluin_a_q   <= 4'd0;
      aluin_b_q   <= 4'd0;
      alu_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= 8'd0;
      rsp_nf_q    <= 1'b0;
      rsp_zf_q    <= 1'b0;
      rsp_cf_q    <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q      <= bus.req_op;
            a_hi_q    <= bus.req_a[7:4];
            b_hi_q    <= bus.req_b[7:4];
            alusel_q  <= low_sel(bus.req_op);
            aluin_a_q <= bus.req_a[3:0];
            aluin_b_q <= bus.req_b[3:0];
            alu_cin_q <= ~bus.req_op[2] & bus.req_op[0] & bus.req_cin;
            state_q   <= S_LOW;
          end
        end
        S_LOW: begin
          res_lo_q  <= bus.alu_y;
          carry_q   <= bus.alu_cf;
          alusel_q  <= high_sel(op_q);
          aluin_a_q <= a_hi_q;
          aluin_b_q <= b_hi_q;
          alu_cin_q <= bus.alu_cf;
          state_q   <= S_HIGH;
        end
        S_HIGH: begin
          rsp_y_q     <= {bus.alu_y, res_lo_q};
          rsp_nf_q    <= bus.alu_y[3];
          rsp_zf_q    <= ({bus.alu_y, res_lo_q} == 8'h00);
          rsp_cf_q    <= ~op_q[2] & bus.alu_cf;
          rsp_ovf_q   <= ~op_q[2] & bus.alu_ovf;
          rsp_valid_q <= 1'b1;
          alusel_q    <= IDLE_SEL;
          aluin_a_q   <= 4'd0;
          aluin_b_q   <= 4'd0;
          alu_cin_q   <= 1'b0;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == S_IDLE) & ~rst;
  assign bus.alusel    = alusel_q;
  assign bus.aluin_a   = aluin_a_q;
  assign bus.aluin_b   = aluin_b_q;
  assign bus.Cin       = alu_cin_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_nf    = rsp_nf_q;
  assign bus.rsp_zf    = rsp_zf_q;
  assign bus.rsp_cf    = rsp_cf_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign dbg_state_o   = state_q;

  // carry_q mirrors the Cin driven on the high pass and is kept for visibility.
  logic unused_carry;
  assign unused_carry = carry_q;

endmodule

// File: tb/tb_alu8_sequencer.sv
// Directed and random 8-bit operations through the sequencer with a nibble ALU model
// attached, checked against whole-byte arithmetic reference results.
module tb_alu8_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  alu8_sequencer_if bus ();

  alu8_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] exp_q[$];

  logic [3:0] low_sel_t  [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB};
  logic [3:0] high_sel_t [8] = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB};

  // 4-bit ALU: 0/1 add (with Cin), 2/3 subtract (with borrow Cin), 8..B logic, else 0.
  function automatic logic [5:0] alu4_model(input logic [3:0] sel, input logic [3:0] a,
                                            input logic [3:0] b, input logic c);
    int         s;
    logic [3:0] y;
    logic       cf;
    logic       ovf;
    y = 4'd0; cf = 1'b0; ovf = 1'b0; s = 0;
    case (sel)
      4'h0, 4'h1: begin
        s   = int'(a) + int'(b) + ((sel[0]) ? int'(c) : 0);
        y   = s[3:0];
        cf  = (s > 15);
        ovf = (a[3] == b[3]) && (y[3] != a[3]);
      end
      4'h2, 4'h3: begin
        s   = int'(a) - int'(b) - ((sel[0]) ? int'(c) : 0);
        y   = s[3:0];
        cf  = (s < 0);
        ovf = (a[3] != b[3]) && (y[3] != a[3]);
      end
      4'h8: y = a | b;
      4'h9: y = a & b;
      4'hA: y = a ^ b;
      4'hB: y = ~a;
      default: y = 4'd0;
    endcase
    return {y, cf, ovf};
  endfunction

  assign {bus.alu_y, bus.alu_cf, bus.alu_ovf} =
    alu4_model(bus.alusel, bus.aluin_a, bus.aluin_b, bus.Cin);

  // Whole-byte result as {y, nf, zf, cf, ovf}.
  function automatic logic [11:0] ref_model(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
    int         u;
    int         sv;
    int         sa;
    int         sb;
    int         c;
    logic [7:0] y;
    logic       cf;
    logic       ovf;
    sa = int'(a); if (a[7]) sa = sa - 256;
    sb = int'(b); if (b[7]) sb = sb - 256;
    c  = (op == 3'd1 || op == 3'd3) ? int'(cin) : 0;
    cf = 1'b0; ovf = 1'b0; y = 8'd0; u = 0; sv = 0;
    case (op)
      3'd0, 3'd1: begin
        u = int'(a) + int'(b) + c; sv = sa + sb + c;
        y = u[7:0]; cf = (u > 255); ovf = (sv > 127) || (sv < -128);
      end
      3'd2, 3'd3: begin
        u = int'(a) - int'(b) - c; sv = sa - sb - c;
        y = u[7:0]; cf = (u < 0); ovf = (sv > 127) || (sv < -128);
      end
      3'd4: y = a | b;
      3'd5: y = a & b;
      3'd6: y = a ^ b;
      default: y = ~a;
    endcase
    return {y, y[7], (y == 8'd0), cf, ovf};
  endfunction

  function automatic logic lo_carry(input logic [2:0] op, input logic [7:0] a,
                                    input logic [7:0] b, input logic cin);
    int s;
    int c;
    c = op[0] ? int'(cin) : 0;
    if (!op[1]) begin
      s = int'(a[3:0]) + int'(b[3:0]) + c;
      return (s > 15);
    end
    s = int'(a[3:0]) - int'(b[3:0]) - c;
    return (s < 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] rsp_bits();
    return {bus.rsp_y, bus.rsp_nf, bus.rsp_zf, bus.rsp_cf, bus.rsp_ovf};
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [11:0] exp, input int hold,
                        input bit poke);
    logic [11:0] e;
    int          waited;
    exp_q.push_back(exp);
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_before", 32'(bus.req_ready), 32'(1));
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cin   = cin;
    bus.rsp_ready = (hold == 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("low_sel", 32'(bus.alusel), 32'(low_sel_t[op]));
    check("low_a", 32'(bus.aluin_a), 32'(a[3:0]));
    check("low_b", 32'(bus.aluin_b), 32'(b[3:0]));
    check("low_cin", 32'(bus.Cin), 32'((op == 3'd1 || op == 3'd3) ? cin : 1'b0));
    check("busy_ready", 32'(bus.req_ready), 32'(0));
    @(negedge clk);
    check("high_sel", 32'(bus.alusel), 32'(high_sel_t[op]));
    check("high_a", 32'(bus.aluin_a), 32'(a[7:4]));
    check("high_b", 32'(bus.aluin_b), 32'(b[7:4]));
    if (!op[2]) check("high_cin", 32'(bus.Cin), 32'(lo_carry(op, a, b, cin)));
    check("early_valid", 32'(bus.rsp_valid), 32'(0));
    @(negedge clk);
    e = exp_q.pop_front();
    check("rsp_valid", 32'(bus.rsp_valid), 32'(1));
    check("rsp", 32'(rsp_bits()), 32'(e));
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.req_valid = 1'b1;
        bus.req_a     = ~a;
      end
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 32'(1));
      check("hold_rsp", 32'(rsp_bits()), 32'(e));
      check("hold_ready", 32'(bus.req_ready), 32'(0));
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("after_valid", 32'(bus.rsp_valid), 32'(0));
    check("after_ready", 32'(bus.req_ready), 32'(1));
    check("after_rsp", 32'(rsp_bits()), 32'(e));
    check("after_sel", 32'(bus.alusel), 32'(4'b0111));
  endtask

  task automatic reset_in_high();
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.req_a     = 8'h3C;
    bus.req_b     = 8'h55;
    bus.req_cin   = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_high_sel", 32'(bus.alusel), 32'(4'b0001));
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready_low", 32'(bus.req_ready), 32'(0));
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst_rsp", 32'(rsp_bits()), 32'(0));
    check("rst_sel", 32'(bus.alusel), 32'(4'b0111));
    check("rst_alu_in", 32'({bus.aluin_a, bus.aluin_b, bus.Cin}), 32'(0));
    check("rst_ready", 32'(bus.req_ready), 32'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_no_rsp", 32'(bus.rsp_valid), 32'(0));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 8'd0;
    bus.req_b     = 8'd0;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_valid", 32'(bus.rsp_valid), 32'(0));
    check("reset_rsp", 32'(rsp_bits()), 32'(0));
    check("reset_sel", 32'(bus.alusel), 32'(4'b0111));
    check("reset_ready_in_rst", 32'(bus.req_ready), 32'(0));
    rst = 1'b0;
    #1;
    check("reset_ready", 32'(bus.req_ready), 32'(1));

    run_op(3'd0, 8'h7F, 8'h01, 1'b0, {8'h80, 1'b1, 1'b0, 1'b0, 1'b1}, 0, 1'b0);
    run_op(3'd0, 8'hFF, 8'h01, 1'b0, {8'h00, 1'b0, 1'b1, 1'b1, 1'b0}, 0, 1'b0);
    run_op(3'd2, 8'h10, 8'h01, 1'b0, {8'h0F, 1'b0, 1'b0, 1'b0, 1'b0}, 1, 1'b0);
    run_op(3'd3, 8'h00, 8'h00, 1'b1, {8'hFF, 1'b1, 1'b0, 1'b1, 1'b0}, 0, 1'b0);
    run_op(3'd1, 8'h0F, 8'h70, 1'b1, {8'h80, 1'b1, 1'b0, 1'b0, 1'b1}, 0, 1'b0);
    run_op(3'd6, 8'hA5, 8'hA5, 1'b0, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}, 5, 1'b1);
    run_op(3'd7, 8'h0F, 8'h33, 1'b1, {8'hF0, 1'b1, 1'b0, 1'b0, 1'b0}, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      op  = 3'($urandom_range(0, 7));
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      run_op(op, a, b, cin, ref_model(op, a, b, cin), $urandom_range(0, 2),
             1'($urandom_range(0, 1)));
    end

    run_op(3'd0, 8'h12, 8'h34, 1'b0, {8'h46, 1'b0, 1'b0, 1'b0, 1'b0}, 0, 1'b0);
    reset_in_high();
    run_op(3'd5, 8'hF3, 8'h3C, 1'b0, ref_model(3'd5, 8'hF3, 8'h3C, 1'b0), 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
